bram_wb_arbiter: RTL and testbench
==================================

Name: bram_wb_arbiter

Overview:
- Two-port Wishbone B3 classic slave arbiter in front of one single-port, synchronous-read block RAM: 1 clock, read data one cycle after address, write when w_en is high.
- Lets the DMA read-side and write-side masters, or the DMA and the CPU/testbench master, share one RAM without collisions.
- Round-robin grant, one transfer in flight, fixed 3-cycle request-to-ack latency.

Parameters:
- DATA_WIDTH, 32, data width of the Wishbone ports and the RAM word.
- ADDR_WIDTH, 14, word-address width of the Wishbone ports and the RAM.
- CNT_WIDTH, 32, width of the grant counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s0_cyc_i / s1_cyc_i  in  1  Wishbone cycle, port 0 / port 1.
- s0_stb_i / s1_stb_i  in  1  strobe.
- s0_we_i / s1_we_i  in  1  1 = write, 0 = read.
- s0_adr_i / s1_adr_i  in  ADDR_WIDTH  word address.
- s0_dat_i / s1_dat_i  in  DATA_WIDTH  write data.
- s0_dat_o / s1_dat_o  out  DATA_WIDTH  read data; valid only while the matching ack is high, 0 otherwise.
- s0_ack_o / s1_ack_o  out  1  single-cycle acknowledge.
- mem_addr  out  ADDR_WIDTH  to RAM addr.
- mem_w_en  out  1  to RAM w_en.
- mem_wdata  out  DATA_WIDTH  to RAM wdata.
- mem_rdata  in  DATA_WIDTH  from RAM rdata.

Behaviour:
- Request: port p requests when cyc&stb = 1.
- States: IDLE, ACCESS, RESP.
- IDLE
  - If any port requests, grant it: register gnt, we_q, adr_q, dat_q from the granted port; go to ACCESS.
  - Else stay in IDLE.
- Arbitration:
  - Pointer prio resets to 0.
  - Single requester always wins.
  - Both requesting: port prio wins.
  - After every grant, prio = other port (~gnt).
- ACCESS
  - mem_addr = adr_q and mem_wdata = dat_q, driven from registers.
  - mem_w_en = we_q & cyc of granted port & ~rst.
  - If granted cyc = 0, abort: no write, go to IDLE, no ack.
  - Else go to RESP.
- RESP
  - mem_rdata is now valid.
  - If granted cyc = 1: ack of granted port = 1 for exactly this cycle; dat_o of granted port = mem_rdata on reads, 0 on writes.
  - Go to IDLE unconditionally.
- Latency: request sampled at edge N → RAM access at N+1 → ack high during cycle N+2.
- Throughput: the master drops stb after ack, so back-to-back transfers from one port have 1 idle cycle; max 1 transfer per 3 cycles.
- Outside ACCESS:
  - mem_w_en = 0.
  - mem_addr and mem_wdata hold their last registered values.
- Ungranted port: ack = 0 and dat_o = 0 always; its request stays pending, no timeout.
- Request changed mid-transfer: adr/we/dat changes on the granted port after the grant are ignored (registered copies are used).
- Reset:
  - All outputs 0, state IDLE, prio 0, gnt 0, we_q 0, adr_q 0, dat_q 0.
  - rst during ACCESS suppresses mem_w_en in that cycle (no RAM write).
  - No ack is issued for a transfer interrupted by rst.
- Starvation: never occurs; with both ports requesting continuously, grants alternate 0,1,0,1.

Optional Feature:
- Macro: BRAM_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (CNT_WIDTH each).
  - Counter p increments on every grant to port p, including grants later aborted.
  - Counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Port 0 writes 0xDEADBEEF to addr 0x0010, then reads addr 0x0010 → each ack is one cycle, 2 cycles after stb sampled; read returns 0xDEADBEEF; s1_ack_o stays 0.
- Both ports request reads of 0x0001 and 0x0002 in the same cycle after reset, RAM preloaded 0x11 / 0x22 → port 0 is acked first with 0x11, port 1 next with 0x22; mem_w_en never high.
- Both ports hold continuous write requests for 8 transfers → grants alternate 0,1,0,1…; exactly 4 acks per port; RAM contents match.
- Port 1 write to 0x0005 drops cyc during ACCESS → mem_w_en stays 0, no ack, RAM[0x0005] unchanged, arbiter returns to IDLE and serves the next request normally.
- rst asserted in the ACCESS cycle of a port 0 write → no RAM write, no ack; after rst all outputs are 0 and prio = 0, so port 0 wins the next tie.
- With BRAM_ARB_STATS_EN and CNT_WIDTH = 2: 5 grants to port 0 → grant_cnt0 = 3 (saturated), grant_cnt1 = 0.

Source files
------------

// File: rtl/bram_wb_arbiter.sv
// Two-port Wishbone B3 classic arbiter in front of a single-port sync-read BRAM; round-robin, one transfer in flight.
// Latency: request sampled at edge N, RAM access during N+1, ack high for one cycle after N+1 (fixed 3-cycle turnaround).
// Backpressure: an ungranted request simply stays pending until served; grant counters exist only with BRAM_ARB_STATS_EN.
module bram_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_cyc_i,
    input  logic                  s0_stb_i,
    input  logic                  s0_we_i,
    input  logic [ADDR_WIDTH-1:0] s0_adr_i,
    input  logic [DATA_WIDTH-1:0] s0_dat_i,
    output logic [DATA_WIDTH-1:0] s0_dat_o,
    output logic                  s0_ack_o,
    input  logic                  s1_cyc_i,
    input  logic                  s1_stb_i,
    input  logic                  s1_we_i,
    input  logic [ADDR_WIDTH-1:0] s1_adr_i,
    input  logic [DATA_WIDTH-1:0] s1_dat_i,
    output logic [DATA_WIDTH-1:0] s1_dat_o,
    output logic                  s1_ack_o,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_w_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic                  prio;
    logic                  gnt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_q;

    logic                  req0, req1, any_req, pick, gnt_cyc, ack_live;
    logic [DATA_WIDTH-1:0] rsp_dat;

    assign req0    = s0_cyc_i & s0_stb_i;
    assign req1    = s1_cyc_i & s1_stb_i;
    assign any_req = req0 | req1;
    // A lone requester wins outright; on a tie the round-robin pointer decides.
    assign pick    = (req0 & req1) ? prio : req1;
    assign gnt_cyc = gnt ? s1_cyc_i : s0_cyc_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            gnt   <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt   <= pick;
                        prio  <= ~pick;
                        we_q  <= pick ? s1_we_i  : s0_we_i;
                        adr_q <= pick ? s1_adr_i : s0_adr_i;
                        dat_q <= pick ? s1_dat_i : s0_dat_i;
                        state <= ACCESS;
                    end
                end
                ACCESS:  state <= gnt_cyc ? RESP : IDLE;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM address/data come straight from the grant-time copies, so they hold between transfers.
    assign mem_addr  = adr_q;
    assign mem_wdata = dat_q;
    assign mem_w_en  = (state == ACCESS) & we_q & gnt_cyc & ~rst;

    assign ack_live  = (state == RESP) & gnt_cyc & ~rst;
    assign rsp_dat   = we_q ? '0 : mem_rdata;
    assign s0_ack_o  = ack_live & ~gnt;
    assign s1_ack_o  = ack_live & gnt;
    assign s0_dat_o  = s0_ack_o ? rsp_dat : '0;
    assign s1_dat_o  = s1_ack_o ? rsp_dat : '0;

`ifdef BRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (state == IDLE && any_req) begin
            if (!pick && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_WIDTH'(1);
            if (pick && grant_cnt1 != '1)  grant_cnt1 <= grant_cnt1 + CNT_WIDTH'(1);
        end
    end
`else
    // Counter width only matters when the grant counters are built.
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

endmodule

// File: tb/tb_bram_wb_arbiter.sv
// Bench for bram_wb_arbiter: behavioural BRAM, directed scenarios and two randomized Wishbone masters
// checked against a shadow memory plus round-robin fairness rules.
module tb_bram_wb_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
`ifdef BRAM_ARB_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 32;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          s0_cyc_i, s0_stb_i, s0_we_i, s1_cyc_i, s1_stb_i, s1_we_i;
    logic [AW-1:0] s0_adr_i, s1_adr_i, mem_addr;
    logic [DW-1:0] s0_dat_i, s1_dat_i, s0_dat_o, s1_dat_o, mem_wdata, mem_rdata;
    logic          s0_ack_o, s1_ack_o, mem_w_en;
`ifdef BRAM_ARB_STATS_EN
    logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .s0_cyc_i(s0_cyc_i), .s0_stb_i(s0_stb_i), .s0_we_i(s0_we_i), .s0_adr_i(s0_adr_i),
        .s0_dat_i(s0_dat_i), .s0_dat_o(s0_dat_o), .s0_ack_o(s0_ack_o),
        .s1_cyc_i(s1_cyc_i), .s1_stb_i(s1_stb_i), .s1_we_i(s1_we_i), .s1_adr_i(s1_adr_i),
        .s1_dat_i(s1_dat_i), .s1_dat_o(s1_dat_o), .s1_ack_o(s1_ack_o),
        .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef BRAM_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    // Behavioural single-port RAM with a backdoor write port for preloading.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_adr = '0;
    logic [DW-1:0] bd_dat = '0;
    always @(posedge clk) begin
        if (mem_w_en) ram[mem_addr] <= mem_wdata;
        if (bd_we) ram[bd_adr] <= bd_dat;
        mem_rdata <= ram[mem_addr];
    end

    logic [DW-1:0] shadow [16];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic c, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        if (p == 0) begin
            s0_cyc_i = c; s0_stb_i = c; s0_we_i = we; s0_adr_i = a; s0_dat_i = d;
        end else begin
            s1_cyc_i = c; s1_stb_i = c; s1_we_i = we; s1_adr_i = a; s1_dat_i = d;
        end
    endtask

    function automatic logic get_ack(input int p);
        return (p == 0) ? s0_ack_o : s1_ack_o;
    endfunction

    function automatic logic [DW-1:0] get_dat(input int p);
        return (p == 0) ? s0_dat_o : s1_dat_o;
    endfunction

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_adr = a; bd_dat = d;
        tick;
        bd_we = 1'b0;
    endtask

    task automatic do_reset;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // One uncontested transfer; lat counts sample points from request to ack (-1 on timeout).
    task automatic do_xfer(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output logic [DW-1:0] rdat, output int lat, output bit other);
        set_req(p, 1'b1, we, a, d);
        lat = -1; other = 0; rdat = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (get_ack(1 - p)) other = 1;
            if (get_ack(p)) begin
                lat = i; rdat = get_dat(p);
                break;
            end
            tick;
        end
        if (lat >= 0) tick;
        set_req(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic run_pair_reads(output int first, output logic [DW-1:0] d0, output logic [DW-1:0] d1,
                                  output int lat0, output int lat1, output bit wen);
        set_req(0, 1'b1, 1'b0, 14'd1, '0);
        set_req(1, 1'b1, 1'b0, 14'd2, '0);
        first = -1; lat0 = -1; lat1 = -1; wen = 0; d0 = '0; d1 = '0;
        for (int i = 0; i < 16 && (lat0 < 0 || lat1 < 0); i++) begin
            @(negedge clk);
            if (mem_w_en) wen = 1;
            if (s0_ack_o && lat0 < 0) begin lat0 = i; d0 = s0_dat_o; if (first < 0) first = 0; end
            if (s1_ack_o && lat1 < 0) begin lat1 = i; d1 = s1_dat_o; if (first < 0) first = 1; end
            tick;
            if (lat0 >= 0) set_req(0, 1'b0, 1'b0, '0, '0);
            if (lat1 >= 0) set_req(1, 1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic test_reset;
        do_reset;
        @(negedge clk);
        n_assert++;
        if ({s0_ack_o, s1_ack_o, mem_w_en, s0_dat_o, s1_dat_o, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack0=%b ack1=%b wen=%b dat0=%h dat1=%h addr=%h wdata=%h, required all 0",
                     s0_ack_o, s1_ack_o, mem_w_en, s0_dat_o, s1_dat_o, mem_addr, mem_wdata);
        end
        tick;
    endtask

    task automatic test_write_read;
        logic [DW-1:0] rd, keep31;
        int lat;
        bit other;
        do_xfer(0, 1'b1, 14'h0010, 32'hDEADBEEF, rd, lat, other);
        n_assert++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d required 2", lat); end
        n_assert++; if (other) begin n_fail++; $display("FAIL wr_s1_ack: got 1 required 0"); end
        n_assert++; if (ram[14'h0010] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wr_ram: got %h required deadbeef", ram[14'h0010]); end
        do_xfer(0, 1'b0, 14'h0010, 32'h0, rd, lat, other);
        n_assert++; if (lat !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d required 2", lat); end
        n_assert++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h required deadbeef", rd); end
        n_assert++; if (other) begin n_fail++; $display("FAIL rd_s1_ack: got 1 required 0"); end
        // Request fields change right after the grant; the original write must land.
        keep31 = ram[14'h0031];
        set_req(0, 1'b1, 1'b1, 14'h0030, 32'hCAFE0001);
        tick;
        set_req(0, 1'b1, 1'b0, 14'h0031, 32'h00000055);
        tick;
        @(negedge clk);
        n_assert++; if (s0_ack_o !== 1'b1) begin n_fail++; $display("FAIL midchg_ack: got %b required 1", s0_ack_o); end
        tick;
        set_req(0, 1'b0, 1'b0, '0, '0);
        tick;
        n_assert++; if (ram[14'h0030] !== 32'hCAFE0001 || ram[14'h0031] !== keep31) begin
            n_fail++; $display("FAIL midchg_ram: got %h/%h required cafe0001/%h", ram[14'h0030], ram[14'h0031], keep31); end
    endtask

    task automatic test_tie;
        int first, lat0, lat1;
        logic [DW-1:0] d0, d1;
        bit wen;
        do_reset;
        bd_write(14'd1, 32'h11);
        bd_write(14'd2, 32'h22);
        run_pair_reads(first, d0, d1, lat0, lat1, wen);
        n_assert++; if (first !== 0) begin n_fail++; $display("FAIL tie_first: got port %0d required 0", first); end
        n_assert++; if (d0 !== 32'h11) begin n_fail++; $display("FAIL tie_d0: got %h required 11", d0); end
        n_assert++; if (d1 !== 32'h22) begin n_fail++; $display("FAIL tie_d1: got %h required 22", d1); end
        n_assert++; if (lat0 !== 2 || lat1 !== 5) begin
            n_fail++; $display("FAIL tie_latency: got %0d/%0d required 2/5", lat0, lat1); end
        n_assert++; if (wen) begin n_fail++; $display("FAIL tie_wen: got 1 required 0"); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] dd [2][4];
        int k [2];
        bit active [2];
        bit cool [2];
        bit drop [2];
        int order [$];
        int cnt [2];
        do_reset;
        for (int p = 0; p < 2; p++) begin
            k[p] = 0; active[p] = 0; cool[p] = 0; cnt[p] = 0;
            for (int j = 0; j < 4; j++) dd[p][j] = $urandom;
        end
        for (int c = 0; c < 80 && order.size() < 8; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (cool[p]) cool[p] = 0;
                else if (!active[p] && k[p] < 4) begin
                    set_req(p, 1'b1, 1'b1, AW'(14'h40 + 14'(p * 14'h40) + 14'(k[p])), dd[p][k[p]]);
                    active[p] = 1;
                end
            end
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                drop[p] = 0;
                if (get_ack(p) && active[p]) begin
                    order.push_back(p); k[p]++; active[p] = 0; drop[p] = 1;
                end
            end
            tick;
            for (int p = 0; p < 2; p++)
                if (drop[p]) begin set_req(p, 1'b0, 1'b0, '0, '0); cool[p] = 1; end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick;
        n_assert++; if (order.size() != 8) begin n_fail++; $display("FAIL b2b_total: got %0d acks required 8", order.size()); end
        foreach (order[i]) begin
            cnt[order[i]]++;
            n_assert++;
            if (order[i] != i % 2) begin n_fail++; $display("FAIL b2b_order[%0d]: got port %0d required %0d", i, order[i], i % 2); end
        end
        n_assert++; if (cnt[0] != 4 || cnt[1] != 4) begin
            n_fail++; $display("FAIL b2b_per_port: got %0d/%0d required 4/4", cnt[0], cnt[1]); end
        for (int p = 0; p < 2; p++)
            for (int j = 0; j < 4; j++) begin
                n_assert++;
                if (ram[14'h40 + p * 14'h40 + j] !== dd[p][j]) begin
                    n_fail++; $display("FAIL b2b_ram p%0d[%0d]: got %h required %h", p, j, ram[14'h40 + p * 14'h40 + j], dd[p][j]);
                end
            end
    endtask

    task automatic test_abort;
        logic [DW-1:0] rd;
        int lat;
        bit other, acked;
        bd_write(14'h0005, 32'hA5A50005);
        set_req(1, 1'b1, 1'b1, 14'h0005, 32'h12345678);
        tick;
        set_req(1, 1'b0, 1'b1, 14'h0005, 32'h12345678);
        @(negedge clk);
        n_assert++; if (mem_w_en !== 1'b0) begin n_fail++; $display("FAIL abort_wen: got %b required 0", mem_w_en); end
        acked = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            @(negedge clk);
            if (s0_ack_o || s1_ack_o) acked = 1;
        end
        tick;
        n_assert++; if (acked) begin n_fail++; $display("FAIL abort_ack: got ack required none"); end
        n_assert++; if (ram[14'h0005] !== 32'hA5A50005) begin
            n_fail++; $display("FAIL abort_ram: got %h required a5a50005", ram[14'h0005]); end
        do_xfer(0, 1'b0, 14'h0005, 32'h0, rd, lat, other);
        n_assert++; if (lat !== 2 || rd !== 32'hA5A50005) begin
            n_fail++; $display("FAIL abort_next: got lat %0d data %h required 2/a5a50005", lat, rd); end
    endtask

    task automatic test_reset_access;
        int first, lat0, lat1;
        logic [DW-1:0] d0, d1;
        bit wen, acked;
        bd_write(14'h0007, 32'h00001234);
        set_req(0, 1'b1, 1'b1, 14'h0007, 32'hFFFF0000);
        tick;
        rst = 1'b1;
        @(negedge clk);
        n_assert++; if (mem_w_en !== 1'b0 || s0_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL rstacc_wen: got wen %b ack %b required 0/0", mem_w_en, s0_ack_o); end
        tick;
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_assert++;
        if ({s0_ack_o, s1_ack_o, mem_w_en, s0_dat_o, s1_dat_o, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL rstacc_outputs: ack0=%b ack1=%b wen=%b addr=%h wdata=%h required all 0",
                     s0_ack_o, s1_ack_o, mem_w_en, mem_addr, mem_wdata);
        end
        acked = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            @(negedge clk);
            if (s0_ack_o || s1_ack_o) acked = 1;
        end
        tick;
        n_assert++; if (acked) begin n_fail++; $display("FAIL rstacc_ack: got ack required none"); end
        n_assert++; if (ram[14'h0007] !== 32'h00001234) begin
            n_fail++; $display("FAIL rstacc_ram: got %h required 00001234", ram[14'h0007]); end
        run_pair_reads(first, d0, d1, lat0, lat1, wen);
        n_assert++; if (first !== 0 || d0 !== 32'h11) begin
            n_fail++; $display("FAIL rstacc_tie: got port %0d data %h required 0/11", first, d0); end
    endtask

    task automatic rand_master(input int p, input int n);
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int others;
        bit got;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 2)) tick;
            we = 1'($urandom_range(0, 1));
            a  = 14'h100 + 14'($urandom_range(0, 15));
            d  = $urandom;
            set_req(p, 1'b1, we, a, d);
            others = 0; got = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (get_ack(1 - p)) others++;
                if (get_ack(p)) begin got = 1; break; end
                n_assert++;
                if (get_dat(p) !== '0) begin n_fail++; $display("FAIL rnd_dat_idle p%0d: got %h required 0", p, get_dat(p)); end
                tick;
            end
            n_assert++;
            if (!got) begin
                n_fail++; $display("FAIL rnd_timeout p%0d: no ack in 12 cycles, required ack", p);
            end else if (!we) begin
                if (get_dat(p) !== shadow[a - 14'h100]) begin
                    n_fail++; $display("FAIL rnd_read p%0d @%h: got %h required %h", p, a, get_dat(p), shadow[a - 14'h100]);
                end
            end else begin
                shadow[a - 14'h100] = d;
            end
            n_assert++;
            if (others > 1) begin n_fail++; $display("FAIL rnd_starve p%0d: other port acked %0d times while pending, required <=1", p, others); end
            if (got) tick;
            set_req(p, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            n_assert++;
            if (get_ack(p) !== 1'b0) begin n_fail++; $display("FAIL rnd_ack_width p%0d: got 1 required 0", p); end
            tick;
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] v;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            shadow[i] = v;
            bd_write(14'h100 + 14'(i), v);
        end
        fork
            rand_master(0, 30);
            rand_master(1, 30);
        join
    endtask

`ifdef BRAM_ARB_STATS_EN
    task automatic test_stats;
        logic [DW-1:0] rd;
        int lat;
        bit other;
        do_reset;
        n_assert++; if (grant_cnt0 !== '0 || grant_cnt1 !== '0) begin
            n_fail++; $display("FAIL stats_reset: got %0d/%0d required 0/0", grant_cnt0, grant_cnt1); end
        repeat (5) do_xfer(0, 1'b0, 14'd1, '0, rd, lat, other);
        n_assert++; if (grant_cnt0 !== 2'd3 || grant_cnt1 !== 2'd0) begin
            n_fail++; $display("FAIL stats_sat: got %0d/%0d required 3/0", grant_cnt0, grant_cnt1); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick;
        test_reset;
        test_write_read;
        test_tie;
        test_back_to_back;
        test_abort;
        test_reset_access;
        test_random;
`ifdef BRAM_ARB_STATS_EN
        test_stats;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
